// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter/timer controller.
//   cmd_op_e : command opcodes carried on cmd_op_i
//   state_e  : controller FSM states
//   mode_e   : timer mode latched on START
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    OpNop           = 2'b00,
    OpStartOneshot  = 2'b01,
    OpStartPeriodic = 2'b10,
    OpStop          = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic {
    ModeOneshot  = 1'b0,
    ModePeriodic = 1'b1
  } mode_e;

  function automatic logic is_start(cmd_op_e op);
    return (op == OpStartOneshot) || (op == OpStartPeriodic);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for the counter/timer controller. Counts 0..divisor_i while enabled
// and pulses tick_o in the cycle the count equals divisor_i, then wraps to 0.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : force count to 0 (takes priority over en_i)
//   en_i         : advance count this cycle
//   divisor_i    : terminal prescale value (tick every divisor_i+1 enabled cycles)
//   tick_o       : combinational tick, valid only while en_i is high
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] divisor_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_d, cnt_q;

  assign tick_o = en_i && (cnt_q == divisor_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Programmable timer controller: accepts START/STOP commands, runs a prescaled
// up-counter to a terminal period, raises a sticky irq on expiry and a sticky
// overrun when an expiry arrives while irq is still pending.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   cmd_valid_i/ready_o : command handshake (always ready)
//   cmd_op_i         : NOP / START_ONESHOT / START_PERIODIC / STOP
//   cmd_period_i     : terminal count, latched on START
//   cmd_prescale_i   : prescale divisor-1, latched on START
//   count_o          : current counter value
//   running_o        : high while in RUN
//   irq_o, irq_ack_i : sticky expiry flag and its clear
//   overrun_o        : sticky missed-interrupt flag (cleared by irq_ack_i)
module counter_timer_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [WIDTH-1:0]      cmd_period_i,
  input  logic [PRESCALE_W-1:0] cmd_prescale_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  running_o,
  output logic                  irq_o,
  input  logic                  irq_ack_i,
  output logic                  overrun_o
);

  state_e                state_d, state_q;
  mode_e                 mode_d, mode_q;
  logic [WIDTH-1:0]      count_d, count_q;
  logic [WIDTH-1:0]      period_d, period_q;
  logic [PRESCALE_W-1:0] prescale_d, prescale_q;
  logic                  irq_d, irq_q;
  logic                  overrun_d, overrun_q;

  cmd_op_e op;
  logic    cmd_fire;
  logic    start_cmd;
  logic    stop_cmd;
  logic    tick;
  logic    expiry;

  assign cmd_ready_o = 1'b1;
  assign op          = cmd_op_e'(cmd_op_i);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign start_cmd   = cmd_fire && is_start(op);
  assign stop_cmd    = cmd_fire && (op == OpStop);

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (start_cmd),
    .en_i      (state_q == StRun),
    .divisor_i (prescale_q),
    .tick_o    (tick)
  );

  // Expiry is evaluated independently of any command so a simultaneous
  // command still lets the irq be raised.
  assign expiry = (state_q == StRun) && tick && (count_q == period_q);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    count_d    = count_q;
    period_d   = period_q;
    prescale_d = prescale_q;

    if (start_cmd) begin
      // Restart identically from any state.
      state_d    = StRun;
      count_d    = '0;
      period_d   = cmd_period_i;
      prescale_d = cmd_prescale_i;
      mode_d     = (op == OpStartPeriodic) ? ModePeriodic : ModeOneshot;
    end else if (stop_cmd) begin
      state_d = StIdle;
    end else if ((state_q == StRun) && tick) begin
      if (count_q == period_q) begin
        if (mode_q == ModePeriodic) begin
          count_d = '0;
        end else begin
          state_d = StDone;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_comb begin
    irq_d     = irq_q;
    overrun_d = overrun_q;
    if (expiry) begin
      // Ack in the same cycle loses to the new expiry.
      irq_d = 1'b1;
      if (irq_q && !irq_ack_i) begin
        overrun_d = 1'b1;
      end
    end else if (irq_ack_i) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      mode_q     <= ModeOneshot;
      count_q    <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      irq_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      irq_q      <= irq_d;
      overrun_q  <= overrun_d;
    end
  end

  assign count_o   = count_q;
  assign running_o = (state_q == StRun);
  assign irq_o     = irq_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench for counter_timer_ctrl.
module tb_counter_timer_ctrl;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PRESCALE_W = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [1:0]            cmd_op = 2'b00;
  logic [WIDTH-1:0]      cmd_period = '0;
  logic [PRESCALE_W-1:0] cmd_prescale = '0;
  logic [WIDTH-1:0]      count;
  logic                  running;
  logic                  irq;
  logic                  irq_ack = 1'b0;
  logic                  overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_timer_ctrl #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_op_i       (cmd_op),
    .cmd_period_i   (cmd_period),
    .cmd_prescale_i (cmd_prescale),
    .count_o        (count),
    .running_o      (running),
    .irq_o          (irq),
    .irq_ack_i      (irq_ack),
    .overrun_o      (overrun)
  );

  // Advance one edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command for exactly one edge.
  task automatic send(input logic [1:0] op, input int period, input int prescale);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_period   = WIDTH'(period);
    cmd_prescale = PRESCALE_W'(prescale);
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready);
    end
    step();
    rst = 1'b0;
    checks++;
    if ({count, running, irq, overrun} !== {8'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d run=%b irq=%b ovr=%b exp 0,0,0,0",
               count, running, irq, overrun);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after got %b exp 1", cmd_ready);
    end
    // NOP and STOP in IDLE do nothing.
    send(2'b00, 5, 0);
    send(2'b11, 5, 0);
    step();
    checks++;
    if ({count, running} !== {8'd0, 1'b0}) begin
      errors++; $display("FAIL idle_nop_stop got cnt=%0d run=%b exp 0,0", count, running);
    end
  endtask

  task automatic test_oneshot();
    send(2'b01, 3, 0);
    checks++;
    if ({running, count} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL os_start got run=%b cnt=%0d exp 1,0", running, count);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({count, irq} !== {8'(k), 1'b0}) begin
        errors++; $display("FAIL os_count%0d got cnt=%0d irq=%b exp %0d,0", k, count, irq, k);
      end
    end
    step();
    checks++;
    if ({irq, running, count, overrun} !== {1'b1, 1'b0, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL os_expire got irq=%b run=%b cnt=%0d ovr=%b exp 1,0,3,0",
               irq, running, count, overrun);
    end
    step();
    step();
    checks++;
    if ({running, count, irq} !== {1'b0, 8'd3, 1'b1}) begin
      errors++; $display("FAIL os_hold got run=%b cnt=%0d irq=%b exp 0,3,1", running, count, irq);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL os_ack got irq=%b exp 0", irq);
    end
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] exp_cnt [1:12];
    exp_cnt = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0};
    send(2'b10, 2, 1);
    checks++;
    if ({running, count} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL per_start got run=%b cnt=%0d exp 1,0", running, count);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (count !== exp_cnt[k]) begin
        errors++; $display("FAIL per_count%0d got %0d exp %0d", k, count, exp_cnt[k]);
      end
      checks++;
      if (irq !== (k >= 6)) begin
        errors++; $display("FAIL per_irq%0d got %b exp %b", k, irq, k >= 6);
      end
    end
    checks++;
    if ({overrun, running} !== 2'b11) begin
      errors++; $display("FAIL per_overrun got ovr=%b run=%b exp 1,1", overrun, running);
    end
    send(2'b11, 0, 0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if ({irq, overrun, running} !== 3'b000) begin
      errors++; $display("FAIL per_cleanup got irq=%b ovr=%b run=%b exp 0,0,0", irq, overrun, running);
    end
  endtask

  task automatic test_overrun_ack();
    send(2'b10, 0, 0);
    step();
    checks++;
    if ({irq, overrun} !== 2'b10) begin
      errors++; $display("FAIL ovr_first got irq=%b ovr=%b exp 1,0", irq, overrun);
    end
    step();
    checks++;
    if ({irq, overrun} !== 2'b11) begin
      errors++; $display("FAIL ovr_second got irq=%b ovr=%b exp 1,1", irq, overrun);
    end
    // Ack coincides with an expiry: nothing clears.
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if ({irq, overrun} !== 2'b11) begin
      errors++; $display("FAIL ovr_ack_on_expiry got irq=%b ovr=%b exp 1,1", irq, overrun);
    end
    send(2'b11, 0, 0);
    checks++;
    if ({running, irq, overrun} !== 3'b011) begin
      errors++; $display("FAIL ovr_stop got run=%b irq=%b ovr=%b exp 0,1,1", running, irq, overrun);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if ({irq, overrun} !== 2'b00) begin
      errors++; $display("FAIL ovr_ack_idle got irq=%b ovr=%b exp 0,0", irq, overrun);
    end
  endtask

  task automatic test_stop_restart();
    send(2'b10, 10, 0);
    for (int k = 1; k <= 5; k++) step();
    checks++;
    if (count !== 8'd5) begin
      errors++; $display("FAIL sr_pre_stop got cnt=%0d exp 5", count);
    end
    send(2'b11, 0, 0);
    step();
    step();
    checks++;
    if ({running, count, irq} !== {1'b0, 8'd5, 1'b0}) begin
      errors++; $display("FAIL sr_stop got run=%b cnt=%0d irq=%b exp 0,5,0", running, count, irq);
    end
    send(2'b10, 4, 0);
    step();
    step();
    checks++;
    if (count !== 8'd2) begin
      errors++; $display("FAIL sr_run2 got cnt=%0d exp 2", count);
    end
    // Restart while running with a new period and mode.
    send(2'b01, 1, 0);
    checks++;
    if ({running, count} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL sr_restart got run=%b cnt=%0d exp 1,0", running, count);
    end
    step();
    step();
    checks++;
    if ({running, count, irq} !== {1'b0, 8'd1, 1'b1}) begin
      errors++; $display("FAIL sr_done got run=%b cnt=%0d irq=%b exp 0,1,1", running, count, irq);
    end
    send(2'b11, 0, 0);
    checks++;
    if ({running, count, irq} !== {1'b0, 8'd1, 1'b1}) begin
      errors++; $display("FAIL sr_stop_done got run=%b cnt=%0d irq=%b exp 0,1,1", running, count, irq);
    end
  endtask

  task automatic test_midrun_reset();
    // irq remains set from the previous scenario.
    send(2'b10, 20, 0);
    for (int k = 1; k <= 7; k++) step();
    checks++;
    if ({count, irq, running} !== {8'd7, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mr_pre got cnt=%0d irq=%b run=%b exp 7,1,1", count, irq, running);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({count, running, irq, overrun, cmd_ready} !== {8'd0, 4'b0001}) begin
      errors++;
      $display("FAIL mr_reset got cnt=%0d run=%b irq=%b ovr=%b rdy=%b exp 0,0,0,0,1",
               count, running, irq, overrun, cmd_ready);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({count, running} !== {8'd0, 1'b0}) begin
      errors++; $display("FAIL mr_idle got cnt=%0d run=%b exp 0,0", count, running);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_overrun_ack();
    test_stop_restart();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
